// File: rtl/axi4_pkg.sv
// Shared AXI4 slave definitions: arbiter state encodings, burst-length type and
// channel encodings used by the slave's channel FSMs.
package axi4_pkg;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ARB_IDLE   = 2'd0;
  localparam arb_state_t ARB_WR_OWN = 2'd1;
  localparam arb_state_t ARB_RD_OWN = 2'd2;

  typedef logic [7:0] burst_len_t;

  // Identity of an engine, as stored in last_served and returned by the picker.
  localparam logic SRC_WR = 1'b0;
  localparam logic SRC_RD = 1'b1;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_rr_pick.sv
// Two-way round-robin pick between the write and read engines.
// On a contest the engine that was not served last wins.
module axi4_rr_pick
  import axi4_pkg::*;
(
  input  logic req_wr,
  input  logic req_rd,
  input  logic last_served,
  output logic winner,
  output logic valid
);

  always_comb begin
    valid  = req_wr | req_rd;
    winner = (req_wr & req_rd) ? ~last_served : (req_rd ? SRC_RD : SRC_WR);
  end

endmodule

// File: rtl/axi4_mem_port_arbiter.sv
// Burst-granular round-robin owner of the single-port backing memory; muxes the
// owning engine's beats onto the memory port and flags beats from the other engine.
module axi4_mem_port_arbiter
  import axi4_pkg::*;
#(
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              ARESETn,
  input  logic              wr_req,
  input  logic [7:0]        wr_len,
  input  logic              wr_beat,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [7:0]        rd_len,
  input  logic              rd_beat,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic              last_beat,
  output logic              proto_err
);

  arb_state_t state_q, state_d;
  burst_len_t len_q, len_d;
  burst_len_t beat_cnt_q, beat_cnt_d;
  logic       last_served_q, last_served_d;
  logic       proto_err_q, proto_err_d;

  logic is_wr, is_rd, own_beat;
  logic pick_last, pick_winner, pick_valid;

  assign is_wr = (state_q == ARB_WR_OWN);
  assign is_rd = (state_q == ARB_RD_OWN);

  // Mid-burst the current owner counts as last served, so a pending request
  // from the other engine wins the handover on the final beat.
  assign pick_last = (state_q == ARB_IDLE) ? last_served_q : (is_rd ? SRC_RD : SRC_WR);

  axi4_rr_pick u_pick (
    .req_wr      (wr_req),
    .req_rd      (rd_req),
    .last_served (pick_last),
    .winner      (pick_winner),
    .valid       (pick_valid)
  );

  always_comb begin
    own_beat      = (is_wr & wr_beat) | (is_rd & rd_beat);
    last_beat     = own_beat & (beat_cnt_q == len_q);
    state_d       = state_q;
    len_d         = len_q;
    beat_cnt_d    = beat_cnt_q;
    last_served_d = last_served_q;
    proto_err_d   = (wr_beat & ~is_wr) | (rd_beat & ~is_rd);

    if ((state_q == ARB_IDLE) || last_beat) begin
      if (last_beat) begin
        last_served_d = is_rd ? SRC_RD : SRC_WR;
      end
      beat_cnt_d = '0;
      if (pick_valid) begin
        state_d = (pick_winner == SRC_RD) ? ARB_RD_OWN : ARB_WR_OWN;
        len_d   = (pick_winner == SRC_RD) ? rd_len : wr_len;
      end else begin
        state_d = ARB_IDLE;
      end
    end else if (own_beat) begin
      beat_cnt_d = beat_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q       <= ARB_IDLE;
      len_q         <= '0;
      beat_cnt_q    <= '0;
      last_served_q <= SRC_RD;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      beat_cnt_q    <= beat_cnt_d;
      last_served_q <= last_served_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign wr_gnt    = is_wr;
  assign rd_gnt    = is_rd;
  assign proto_err = proto_err_q;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    case (state_q)
      ARB_WR_OWN: begin
        mem_en    = wr_beat;
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        mem_wstrb = wr_strb;
      end
      ARB_RD_OWN: begin
        mem_en   = rd_beat;
        mem_addr = rd_addr;
      end
      default: ;
    endcase
  end

endmodule
